opb_register_bank_simulink2ppc: RTL and testbench

//  Multi-channel successor to the single simulink->PPC readout register. Presents C_NUM_CH user

---
 rtl/opb_register_bank_simulink2ppc_pkg.sv | 31 +++
 rtl/opb_register_bank_simulink2ppc_if.sv | 26 ++
 rtl/opb_register_bank_simulink2ppc_slave_if.sv | 71 +++++++
 rtl/opb_register_bank_simulink2ppc.sv | 113 +++++++++++
 tb/tb_opb_register_bank_simulink2ppc.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/opb_register_bank_simulink2ppc_pkg.sv
// Shared constants and types for the multi-channel OPB readout register bank:
// word offsets, capture modes, CTRL bit positions and FSM encodings.
package opb_regbank_pkg;

  typedef logic [29:0] woff_t;

  localparam woff_t OFF_CTRL     = 30'd0;
  localparam woff_t OFF_STATUS   = 30'd1;
  localparam woff_t OFF_SNAP_CNT = 30'd2;
  localparam woff_t OFF_DATA     = 30'd3;

  localparam logic [1:0] MODE_LIVE = 2'd0;
  localparam logic [1:0] MODE_SNAP = 2'd1;
  localparam logic [1:0] MODE_HOLD = 2'd2;  // 3 also decodes as HOLD

  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_ARM      = 4;
  localparam int CTRL_DONE     = 5;

  typedef enum logic [1:0] {SL_IDLE, SL_ACK, SL_WAIT} sl_state_e;
  typedef enum logic [1:0] {CAP_IDLE, CAP_ARMED, CAP_DONE} cap_state_e;

  // Single-cycle register access issued by the bus slave on the first select cycle
  typedef struct packed {
    logic       rd;
    logic       wr;
    woff_t      off;
    logic [7:0] wdata;
  } reg_req_t;

endpackage

// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB slave-side bus bundle; vectors keep the big-endian OPB bit numbering (bit 0 = MSB).
interface opb_register_bank_simulink2ppc_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [0:AW-1]   OPB_ABus;
  logic [0:DW/8-1] OPB_BE;
  logic [0:DW-1]   OPB_DBus;
  logic            OPB_RNW;
  logic            OPB_select;
  logic            OPB_seqAddr;
  logic [0:DW-1]   Sl_DBus;
  logic            Sl_xferAck;
  logic            Sl_errAck;
  logic            Sl_retry;
  logic            Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_bank_simulink2ppc_slave_if.sv
// OPB address decode and IDLE/ACK/WAIT handshake. Issues one rd/wr strobe per transfer
// and registers the read word so it is presented together with the single ack.
module opb_slave_if
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0200,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_02FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  opb_register_bank_simulink2ppc_if.slave opb,
  output reg_req_t                req,
  input  logic [C_OPB_DWIDTH-1:0] rd_data
);
  localparam logic [C_OPB_AWIDTH-1:0] BASE = C_OPB_AWIDTH'(C_BASEADDR);
  localparam logic [C_OPB_AWIDTH-1:0] HIGH = C_OPB_AWIDTH'(C_HIGHADDR);
  localparam int BE_LSB = C_OPB_DWIDTH/8 - 1;

  sl_state_e                 state;
  logic                      ack_q;
  logic [C_OPB_DWIDTH-1:0]   dbus_q;
  logic [C_OPB_AWIDTH-1:0]   addr, off;
  logic                      hit, start;
  logic                      unused_bits;

  assign addr  = opb.OPB_ABus;
  assign hit   = opb.OPB_select && (addr >= BASE) && (addr <= HIGH);
  assign off   = addr - BASE;
  assign start = (state == SL_IDLE) && hit;

  // Only the least-significant byte lane carries writable bits
  assign unused_bits = ^{opb.OPB_seqAddr, opb.OPB_BE, opb.OPB_DBus[0:C_OPB_DWIDTH-9]};

  always_comb begin
    req       = '0;
    req.rd    = start && opb.OPB_RNW;
    req.wr    = start && !opb.OPB_RNW && opb.OPB_BE[BE_LSB];
    req.off   = 30'(off >> 2);
    req.wdata = opb.OPB_DBus[C_OPB_DWIDTH-8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SL_IDLE;
      ack_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      case (state)
        SL_IDLE: if (hit) begin
          state  <= SL_ACK;
          ack_q  <= 1'b1;
          dbus_q <= opb.OPB_RNW ? rd_data : '0;
        end
        SL_ACK: begin
          state  <= SL_WAIT;
          ack_q  <= 1'b0;
          dbus_q <= '0;
        end
        // Hold off until the master drops select so a long select gets one ack only
        SL_WAIT: if (!opb.OPB_select) state <= SL_IDLE;
        default: state <= SL_IDLE;
      endcase
    end
  end

  assign opb.Sl_xferAck = ack_q;
  assign opb.Sl_DBus    = dbus_q;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel simulink->PPC readout bank: CTRL with LIVE/SNAP/HOLD capture, per-channel
// new-data flags cleared on STATUS read, armed snapshot on user_trig and a snapshot counter.
module opb_register_bank_simulink2ppc
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR    = 32'h0100_0200,
  parameter logic [31:0] C_HIGHADDR    = 32'h0100_02FF,
  parameter int          C_OPB_AWIDTH  = 32,
  parameter int          C_OPB_DWIDTH  = 32,
  parameter int          C_NUM_CH      = 8,
  parameter int          C_USER_DWIDTH = 32,
  parameter string       C_FAMILY      = "virtex6"
) (
  input  logic                              OPB_Clk,
  input  logic                              OPB_Rst_n,
  opb_register_bank_simulink2ppc_if.slave   opb,
  input  logic [C_NUM_CH*C_USER_DWIDTH-1:0] user_data_in,
  input  logic [C_NUM_CH-1:0]               user_valid,
  input  logic                              user_trig
);
  localparam int N = C_NUM_CH;
  localparam int W = C_USER_DWIDTH;
  localparam bit unused_family = (C_FAMILY != "");

  reg_req_t                req;
  logic [C_OPB_DWIDTH-1:0] rd_data;

  logic [1:0]              mode_q;
  cap_state_e              cap_state;
  logic [31:0]             snap_cnt;
  logic [N-1:0][W-1:0]     data_q;
  logic [N-1:0]            flag_q;
  logic [N-1:0]            load;

  logic       ctrl_wr, arm_wr, mode_chg, cap_fire, status_rd;
  logic [1:0] new_mode;

  opb_slave_if #(
    .C_BASEADDR  (C_BASEADDR),
    .C_HIGHADDR  (C_HIGHADDR),
    .C_OPB_AWIDTH(C_OPB_AWIDTH),
    .C_OPB_DWIDTH(C_OPB_DWIDTH)
  ) u_slave (
    .clk    (OPB_Clk),
    .rst_n  (OPB_Rst_n),
    .opb    (opb),
    .req    (req),
    .rd_data(rd_data)
  );

  assign opb.Sl_errAck  = 1'b0;
  assign opb.Sl_retry   = 1'b0;
  assign opb.Sl_toutSup = 1'b0;

  assign ctrl_wr   = req.wr && (req.off == OFF_CTRL);
  assign new_mode  = req.wdata[CTRL_MODE_LSB +: 2];
  assign arm_wr    = ctrl_wr && req.wdata[CTRL_ARM];
  assign mode_chg  = ctrl_wr && (new_mode != mode_q);
  assign status_rd = req.rd && (req.off == OFF_STATUS);

  // A mode-changing CTRL write in the trigger cycle takes precedence over the capture
  assign cap_fire  = user_trig && (cap_state == CAP_ARMED) && (mode_q == MODE_SNAP) && !mode_chg;

  assign load = ({N{mode_q == MODE_LIVE}} & user_valid) | {N{cap_fire}};

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      mode_q    <= MODE_LIVE;
      cap_state <= CAP_IDLE;
      snap_cnt  <= '0;
    end else begin
      if (ctrl_wr) mode_q <= new_mode;
      // ARM is evaluated against the post-write mode so one write can select SNAP and arm
      if (arm_wr && (new_mode == MODE_SNAP) && (mode_chg || cap_state != CAP_ARMED))
        cap_state <= CAP_ARMED;
      else if (mode_chg)
        cap_state <= CAP_IDLE;
      else if (cap_fire)
        cap_state <= CAP_DONE;
      if (cap_fire) snap_cnt <= snap_cnt + 32'd1;
    end
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      data_q <= '0;
      flag_q <= '0;
    end else begin
      for (int k = 0; k < N; k++)
        if (load[k]) data_q[k] <= user_data_in[k*W +: W];
      // Set beats the read-clear; the clear only hits bits the read returned
      flag_q <= load | (flag_q & ~{N{status_rd}});
    end
  end

  always_comb begin
    rd_data = '0;
    case (req.off)
      OFF_CTRL: begin
        rd_data[CTRL_MODE_LSB +: 2] = mode_q;
        rd_data[CTRL_ARM]           = (cap_state == CAP_ARMED);
        rd_data[CTRL_DONE]          = (cap_state == CAP_DONE);
      end
      OFF_STATUS:   rd_data[N-1:0] = flag_q;
      OFF_SNAP_CNT: rd_data        = C_OPB_DWIDTH'(snap_cnt);
      default: begin
        for (int k = 0; k < N; k++)
          if (req.off == OFF_DATA + woff_t'(k)) rd_data[W-1:0] = data_q[k];
      end
    endcase
  end

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed bench for the 4-channel, 16-bit configuration of the OPB register bank.
module tb_opb_register_bank_simulink2ppc;
  localparam logic [31:0] BASE = 32'h0100_0200;
  localparam logic [31:0] HIGH = 32'h0100_02FF;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst_n;
  logic [63:0] user_data_in;
  logic [3:0]  user_valid;
  logic        user_trig;
  int          ntests = 0;
  int          nfail  = 0;
  bit          mon_en = 1'b0;

  opb_register_bank_simulink2ppc_if bus ();

  opb_register_bank_simulink2ppc #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_CH(4), .C_USER_DWIDTH(16), .C_FAMILY("virtex6")
  ) dut (
    .OPB_Clk     (OPB_Clk),
    .OPB_Rst_n   (OPB_Rst_n),
    .opb         (bus),
    .user_data_in(user_data_in),
    .user_valid  (user_valid),
    .user_trig   (user_trig)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave outputs must idle at zero whenever no ack is on the bus
  always @(negedge OPB_Clk)
    if (mon_en && !bus.Sl_xferAck)
      check("sl_idle", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup, bus.Sl_DBus}, 64'h0);

  // Entered on a negedge; optional valid/trig pulses coincide with select cycle 0
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input logic [3:0] vmask, input logic trig,
                      output logic [31:0] rdata);
    bit got = 0;
    rdata = '0;
    bus.OPB_ABus = addr; bus.OPB_RNW = rnw; bus.OPB_DBus = wdata; bus.OPB_BE = be;
    bus.OPB_select = 1'b1; user_valid = vmask; user_trig = trig;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge OPB_Clk);
      user_valid = '0; user_trig = 1'b0;
      if (bus.Sl_xferAck) begin got = 1; rdata = bus.Sl_DBus; end
    end
    bus.OPB_select = 1'b0; bus.OPB_DBus = '0;
    check("xfer_ack", 64'(got), 64'd1);
    repeat (2) @(negedge OPB_Clk);
  endtask

  task automatic rd(input string tag, input logic [29:0] off, input logic [31:0] exp);
    logic [31:0] d;
    xfer(1'b1, BASE + {off, 2'b00}, 32'h0, 4'hF, 4'h0, 1'b0, d);
    check(tag, 64'(d), 64'(exp));
  endtask

  task automatic wr(input logic [29:0] off, input logic [31:0] v, input logic [3:0] be);
    logic [31:0] d;
    xfer(1'b0, BASE + {off, 2'b00}, v, be, 4'h0, 1'b0, d);
  endtask

  task automatic pulse(input logic [3:0] v, input logic t);
    user_valid = v; user_trig = t;
    @(negedge OPB_Clk);
    user_valid = '0; user_trig = 1'b0;
  endtask

  task automatic hold_select(input logic [31:0] addr, input int cycles,
                             output int cnt, output int first);
    cnt = 0; first = -1;
    bus.OPB_ABus = addr; bus.OPB_RNW = 1'b1; bus.OPB_BE = 4'hF; bus.OPB_select = 1'b1;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge OPB_Clk);
      if (bus.Sl_xferAck) begin cnt++; if (first < 0) first = i; end
    end
    bus.OPB_select = 1'b0;
    repeat (3) @(negedge OPB_Clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int cnt, first;
    OPB_Rst_n = 1'b0; user_data_in = '0; user_valid = '0; user_trig = 1'b0;
    bus.OPB_ABus = '0; bus.OPB_BE = '0; bus.OPB_DBus = '0; bus.OPB_RNW = 1'b1;
    bus.OPB_select = 1'b0; bus.OPB_seqAddr = 1'b0;
    repeat (3) @(negedge OPB_Clk);
    check("rst_ack", 64'(bus.Sl_xferAck), 64'd0);
    check("rst_dbus", 64'(bus.Sl_DBus), 64'd0);
    OPB_Rst_n = 1'b1; mon_en = 1'b1;
    @(negedge OPB_Clk);

    // 1: reset contents
    rd("rst_ctrl", 0, 32'h0);   rd("rst_status", 1, 32'h0); rd("rst_cnt", 2, 32'h0);
    rd("rst_d0", 3, 32'h0);     rd("rst_d1", 4, 32'h0);
    rd("rst_d2", 5, 32'h0);     rd("rst_d3", 6, 32'h0);

    // 2: LIVE updates and flag read-clear
    user_data_in = {16'h0, 16'hBEEF, 16'h0, 16'h0};
    pulse(4'b0100, 1'b0);
    rd("live_d2", 5, 32'h0000_BEEF);
    rd("live_d0_indep", 3, 32'h0);
    rd("live_status", 1, 32'h4);
    rd("live_status_clr", 1, 32'h0);
    user_data_in = {16'h0, 16'hBEEF, 16'h1234, 16'h0};
    pulse(4'b0010, 1'b0);
    xfer(1'b1, BASE + 32'h4, 32'h0, 4'hF, 4'b0010, 1'b0, d);
    check("live_status_rdset", 64'(d), 64'h2);
    rd("live_set_wins", 1, 32'h2);
    rd("live_d1", 4, 32'h0000_1234);

    // 3: SNAP mode, armed capture, counter
    wr(0, 32'h11, 4'hF);
    rd("snap_ctrl_armed", 0, 32'h11);
    user_data_in = {4{16'hA0A0}};
    pulse(4'hF, 1'b0);
    rd("snap_valid_ignored", 3, 32'h0);
    rd("snap_status_quiet", 1, 32'h0);
    user_data_in = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    pulse(4'h0, 1'b1);
    user_data_in = {4{16'h5555}};
    rd("snap_d0", 3, 32'h1111); rd("snap_d1", 4, 32'h2222);
    rd("snap_d2", 5, 32'h3333); rd("snap_d3", 6, 32'h4444);
    rd("snap_status", 1, 32'hF);
    rd("snap_cnt1", 2, 32'h1);
    rd("snap_ctrl_done", 0, 32'h21);
    pulse(4'h0, 1'b1);
    rd("snap_noarm_d3", 6, 32'h4444);
    rd("snap_noarm_cnt", 2, 32'h1);
    rd("snap_noarm_status", 1, 32'h0);
    xfer(1'b0, BASE, 32'h11, 4'hF, 4'h0, 1'b1, d);
    rd("arm_trig_same_cnt", 2, 32'h1);
    rd("arm_trig_same_ctrl", 0, 32'h11);
    pulse(4'h0, 1'b1);
    rd("snap_cnt2", 2, 32'h2);
    rd("snap2_d0", 3, 32'h5555);
    rd("snap2_ctrl", 0, 32'h21);

    // 4: handshake, range, RO and byte-enable writes
    hold_select(BASE, 5, cnt, first);
    check("hold_ack_cnt", 64'(cnt), 64'd1);
    check("hold_ack_cycle", 64'(first), 64'd1);
    hold_select(HIGH + 32'h4, 4, cnt, first);
    check("oor_no_ack", 64'(cnt), 64'd0);
    rd("unmapped_rd", 7, 32'h0);
    wr(7, 32'hFF, 4'hF);
    wr(2, 32'h0, 4'hF);
    rd("ro_cnt_kept", 2, 32'h2);
    wr(3, 32'h0, 4'hF);
    rd("ro_data_kept", 3, 32'h5555);
    wr(0, 32'h02, 4'h0);
    rd("be_off_ignored", 0, 32'h21);

    // 5: async reset during ACK
    wr(0, 32'h11, 4'hF);
    rd("pre_rst_armed", 0, 32'h11);
    bus.OPB_ABus = BASE; bus.OPB_RNW = 1'b1; bus.OPB_select = 1'b1;
    @(posedge OPB_Clk); #2;
    check("ack_before_rst", 64'(bus.Sl_xferAck), 64'd1);
    OPB_Rst_n = 1'b0; #1;
    check("ack_async_drop", 64'(bus.Sl_xferAck), 64'd0);
    check("dbus_async_drop", 64'(bus.Sl_DBus), 64'd0);
    @(negedge OPB_Clk); bus.OPB_select = 1'b0;
    @(negedge OPB_Clk); OPB_Rst_n = 1'b1;
    @(negedge OPB_Clk);
    rd("post_rst_ctrl", 0, 32'h0);
    rd("post_rst_cnt", 2, 32'h0);
    rd("post_rst_d0", 3, 32'h0);

    // 6: mode change disarms, HOLD, counter wrap
    wr(0, 32'h11, 4'hF);
    rd("m6_armed", 0, 32'h11);
    wr(0, 32'h02, 4'hF);
    rd("m6_hold_disarm", 0, 32'h02);
    user_data_in = {4{16'h7777}};
    pulse(4'hF, 1'b1);
    rd("hold_cnt", 2, 32'h0);
    rd("hold_d0", 3, 32'h0);
    rd("hold_status", 1, 32'h0);
    wr(0, 32'h11, 4'hF);
    force dut.snap_cnt = 32'hFFFF_FFFF;
    @(negedge OPB_Clk);
    release dut.snap_cnt;
    pulse(4'h0, 1'b1);
    rd("wrap_cnt", 2, 32'h0);
    rd("wrap_ctrl", 0, 32'h21);
    rd("wrap_d0", 3, 32'h7777);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
